alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_muldiv_iter.sv | 97 +++++++++
 rtl/alu_multicycle.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, state encoding and flag payload for alu_multicycle.
package alu_pkg;

  localparam int unsigned SEL_WIDTH = 5;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam sel_t OP_ADD  = 5'd0;
  localparam sel_t OP_SUB  = 5'd1;
  localparam sel_t OP_AND  = 5'd2;
  localparam sel_t OP_OR   = 5'd3;
  localparam sel_t OP_XOR  = 5'd4;
  localparam sel_t OP_NOR  = 5'd5;
  localparam sel_t OP_NAND = 5'd6;
  localparam sel_t OP_XNOR = 5'd7;
  localparam sel_t OP_EQU  = 5'd8;
  localparam sel_t OP_GT   = 5'd9;
  localparam sel_t OP_LT   = 5'd10;
  localparam sel_t OP_ROR  = 5'd11;
  localparam sel_t OP_ROL  = 5'd12;
  localparam sel_t OP_MULT = 5'd13;
  localparam sel_t OP_DIV  = 5'd14;
  localparam sel_t OP_MFLO = 5'd15;
  localparam sel_t OP_MFHI = 5'd16;

  // Operation select for the iterative multiply/divide engine
  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic error;
  } flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative one-bit-per-cycle engine: LSB-first shift-add multiply and
// restoring divide. The first iteration happens on the start edge, so the
// registered done pulse follows WIDTH iterations.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_b;
  logic             w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // One iteration step; on start the operands come straight from the inputs
  always_comb begin
    w_acc     = start ? '0 : r_acc;
    w_q       = start ? a  : r_q;
    w_b       = start ? b  : r_b;
    w_op      = start ? op : r_op;
    w_sum     = {1'b0, w_acc} + (w_q[0] ? {1'b0, w_b} : '0);
    w_shift   = {w_acc, w_q[WIDTH-1]};
    w_trial   = w_shift - {1'b0, w_b};
    w_acc_nxt = w_sum[WIDTH:1];
    w_q_nxt   = {w_sum[0], w_q[WIDTH-1:1]};
    if (w_op == MD_DIV) begin
      if (!w_trial[WIDTH]) begin
        w_acc_nxt = w_trial[WIDTH-1:0];
        w_q_nxt   = {w_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shift[WIDTH-1:0];
        w_q_nxt   = {w_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Iteration registers, counter and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_q    <= '0;
      r_b    <= '0;
      r_op   <= MD_MUL;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc  <= w_acc_nxt;
        r_q    <= w_q_nxt;
        r_b    <= b;
        r_op   <= op;
        r_cnt  <= CNT_W'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign hi   = r_acc;
  assign lo   = r_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes on request and result.
// Define ALU_MULTICYCLE_MULDIV_EN to build MULT/DIV/MFLO/MFHI, the HI/LO
// registers and the iterative datapath; otherwise those opcodes are invalid.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 zero,
  output logic                 carry,
  output logic                 overflow,
  output logic                 error
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  flags_t           r_flg;

  logic             w_load_single;
  logic [WIDTH-1:0] w_res;
  flags_t           w_flg;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [SH_W-1:0]  w_sh;
  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_ror_full;
  logic [2*WIDTH-1:0] w_rol_full;

`ifdef ALU_MULTICYCLE_MULDIV_EN
  logic             w_is_iter;
  logic             w_start;
  logic             w_load_iter;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  flags_t           w_md_flg;
  logic             r_md_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  assign w_is_iter = (sel == OP_MULT) || ((sel == OP_DIV) && (b != '0));

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .op    ((sel == OP_DIV) ? MD_DIV : MD_MUL),
    .a     (a),
    .b     (b),
    .done  (w_md_done),
    .hi    (w_md_hi),
    .lo    (w_md_lo)
  );

  // Flags for a completed MULT/DIV; carry reports a non-zero HI on MULT
  always_comb begin
    w_md_flg          = '0;
    w_md_flg.zero     = (w_md_lo == '0);
    w_md_flg.carry    = (r_md_op == MD_MUL) && (w_md_hi != '0);
  end

  // Remember which iterative op is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_op <= MD_MUL;
    end else if (w_start) begin
      r_md_op <= (sel == OP_DIV) ? MD_DIV : MD_MUL;
    end
  end
`endif

  assign w_add      = {1'b0, a} + {1'b0, b};
  assign w_sub      = {1'b0, a} - {1'b0, b};
  assign w_sh       = SH_W'(32'(b) % WIDTH);
  assign w_dbl      = {a, a};
  assign w_ror_full = w_dbl >> w_sh;
  assign w_rol_full = w_dbl << w_sh;

  // Single-cycle result and flags for the current request
  always_comb begin
    w_res = '0;
    w_flg = '0;
    case (sel)
      OP_ADD: begin
        w_res          = w_add[WIDTH-1:0];
        w_flg.carry    = w_add[WIDTH];
        w_flg.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res          = w_sub[WIDTH-1:0];
        w_flg.carry    = w_sub[WIDTH];
        w_flg.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_NAND: w_res = ~(a & b);
      OP_XNOR: w_res = ~(a ^ b);
      OP_EQU:  w_res = WIDTH'(a == b);
      OP_GT:   w_res = WIDTH'(a > b);
      OP_LT:   w_res = WIDTH'(a < b);
      OP_ROR:  w_res = w_ror_full[WIDTH-1:0];
      OP_ROL:  w_res = w_rol_full[2*WIDTH-1:WIDTH];
`ifdef ALU_MULTICYCLE_MULDIV_EN
      OP_MULT: w_res = '0;
      OP_DIV:  w_flg.error = 1'b1;
      OP_MFLO: w_res = r_lo;
      OP_MFHI: w_res = r_hi;
`endif
      default: w_flg.error = 1'b1;
    endcase
    w_flg.zero = (w_res == '0);
  end

  // Next-state and datapath load strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_load_single = 1'b0;
`ifdef ALU_MULTICYCLE_MULDIV_EN
    w_start       = 1'b0;
    w_load_iter   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
          if (w_is_iter) begin
            w_state_nxt = ST_BUSY;
            w_start     = 1'b1;
          end else begin
            w_state_nxt   = ST_DONE;
            w_load_single = 1'b1;
          end
`else
          w_state_nxt   = ST_DONE;
          w_load_single = 1'b1;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
        if (w_md_done) begin
          w_state_nxt = ST_DONE;
          w_load_iter = 1'b1;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  // Result, flags and HI/LO; held while the result waits for out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_flg <= '0;
`ifdef ALU_MULTICYCLE_MULDIV_EN
      r_hi  <= '0;
      r_lo  <= '0;
`endif
    end else if (w_load_single) begin
      r_out <= w_res;
      r_flg <= w_flg;
    end
`ifdef ALU_MULTICYCLE_MULDIV_EN
    else if (w_load_iter) begin
      r_out <= w_md_lo;
      r_flg <= w_md_flg;
      r_hi  <= w_md_hi;
      r_lo  <= w_md_lo;
    end
`endif
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zero      = r_flg.zero;
  assign carry     = r_flg.carry;
  assign overflow  = r_flg.overflow;
  assign error     = r_flg.error;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=8. Multiply/divide vectors run
// when ALU_MULTICYCLE_MULDIV_EN is defined; otherwise opcodes 13..16 are
// expected to behave as invalid.
module tb_alu_multicycle;

  localparam int unsigned O_ADD = 0, O_SUB = 1, O_AND = 2, O_OR = 3, O_XOR = 4;
  localparam int unsigned O_NOR = 5, O_NAND = 6, O_XNOR = 7, O_EQU = 8, O_GT = 9;
  localparam int unsigned O_LT = 10, O_ROR = 11, O_ROL = 12, O_MULT = 13;
  localparam int unsigned O_DIV = 14, O_MFLO = 15, O_MFHI = 16;
  // Flag vector {zero, carry, overflow, error}
  localparam int unsigned F_Z = 8, F_C = 4, F_O = 2, F_E = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [4:0] sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic       zero, carry, overflow, error;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] flags();
    return 32'({zero, carry, overflow, error});
  endfunction

  // Present a request and return just after the accepting edge
  task automatic send(input string tag, input int unsigned s, input int unsigned x,
                      input int unsigned y);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    sel = 5'(s);
    a   = 8'(x);
    b   = 8'(y);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int unsigned s, input int unsigned x,
                        input int unsigned y, input int unsigned eo,
                        input int unsigned ef, input int unsigned el);
    int lat;
    send(tag, s, x, y);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), el);
    check({tag, " out"}, 32'(out), eo);
    check({tag, " flags"}, flags(), ef);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out", 32'(out), 0);
    check("rst flags", flags(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 1);

    // Arithmetic
    run_op("add 200+100", O_ADD, 200, 100, 44, F_C, 1);
    run_op("add 100+50", O_ADD, 100, 50, 150, F_O, 1);
    run_op("sub 5-10", O_SUB, 5, 10, 251, F_C, 1);
    run_op("sub 80h-1", O_SUB, 'h80, 1, 'h7F, F_O, 1);

    // Logic
    run_op("and", O_AND, 'hC5, 'h3A, 'h00, F_Z, 1);
    run_op("or", O_OR, 'hC5, 'h3A, 'hFF, 0, 1);
    run_op("xor", O_XOR, 'hC5, 'h3A, 'hFF, 0, 1);
    run_op("nor", O_NOR, 'hC5, 'h3A, 'h00, F_Z, 1);
    run_op("nand", O_NAND, 'hC5, 'h3A, 'hFF, 0, 1);
    run_op("xnor", O_XNOR, 'hC5, 'h3A, 'h00, F_Z, 1);

    // Compare and rotate
    run_op("equ", O_EQU, 7, 7, 1, 0, 1);
    run_op("gt", O_GT, 9, 3, 1, 0, 1);
    run_op("lt", O_LT, 9, 3, 0, F_Z, 1);
    run_op("ror 1", O_ROR, 'h81, 1, 'hC0, 0, 1);
    run_op("rol 9", O_ROL, 'h81, 9, 'h03, 0, 1);
    run_op("ror 8", O_ROR, 'h81, 8, 'h81, 0, 1);

    // Invalid opcode
    run_op("sel 20", 20, 'h12, 'h34, 0, F_Z | F_E, 1);

    // Back-pressure: result held, next request waits for the handshake
    send("bp", O_ADD, 1, 2);
    wait_valid(lat);
    check("bp latency", 32'(lat), 1);
    in_valid = 1'b1;
    sel = 5'(O_AND);
    a = 8'hF0;
    b = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp hold out", 32'(out), 3);
      check("bp hold valid", 32'(out_valid), 1);
      check("bp hold in_ready", 32'(in_ready), 0);
    end
    check("bp hold flags", flags(), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release valid", 32'(out_valid), 0);
    check("bp release in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp next valid", 32'(out_valid), 1);
    check("bp next out", 32'(out), 0);
    check("bp next flags", flags(), F_Z);
    consume();

    // Reset while a result is waiting
    send("rst done", O_ADD, 3, 4);
    wait_valid(lat);
    check("rst done pre out", 32'(out), 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst done valid", 32'(out_valid), 0);
    check("rst done out", 32'(out), 0);
    check("rst done in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    check("rst done stays idle", 32'(out_valid), 0);

`ifdef ALU_MULTICYCLE_MULDIV_EN
    run_op("mult 200*3", O_MULT, 200, 3, 'h58, F_C, 9);
    run_op("mfhi mult", O_MFHI, 0, 0, 'h02, 0, 1);
    run_op("mflo mult", O_MFLO, 0, 0, 'h58, 0, 1);
    run_op("div 250/7", O_DIV, 250, 7, 35, 0, 9);
    run_op("mfhi div", O_MFHI, 0, 0, 5, 0, 1);
    run_op("div 7/0", O_DIV, 7, 0, 0, F_Z | F_E, 1);
    run_op("mfhi after div0", O_MFHI, 0, 0, 5, 0, 1);

    // Reset on the 4th BUSY cycle of a MULT
    send("mult abort", O_MULT, 200, 3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort in_ready", 32'(in_ready), 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", 32'(seen), 0);
    run_op("abort mfhi", O_MFHI, 0, 0, 0, F_Z, 1);
    run_op("abort mflo", O_MFLO, 0, 0, 0, F_Z, 1);
    run_op("abort sel 20", 20, 1, 1, 0, F_Z | F_E, 1);
`else
    run_op("mult disabled", O_MULT, 200, 3, 0, F_Z | F_E, 1);
    run_op("div disabled", O_DIV, 250, 7, 0, F_Z | F_E, 1);
    run_op("mflo disabled", O_MFLO, 0, 0, 0, F_Z | F_E, 1);
    run_op("mfhi disabled", O_MFHI, 0, 0, 0, F_Z | F_E, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
